// File: rtl/a2d_spi_master.sv
// SPI master for the 8-channel 12-bit A2D converter.
// One start pulse produces two 16-bit frames. Frame 1 sends the channel command.
// Frame 2 resends the same command and shifts the conversion result back in.
// SCLK idles high and has a period of 2**DIV_BITS clk.
// MOSI changes on SCLK falling edges. MISO is sampled one clk before each SCLK rise.
module a2d_spi_master #(
    parameter int unsigned DIV_BITS = 5,
    parameter int unsigned GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        a2d_SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    localparam int unsigned GapW = $clog2(GAP_CLKS) + 1;
    // Frame starts with SCLK high, a quarter period plus one clk ahead of the first fall.
    localparam logic [DIV_BITS-1:0] CntLoad =
        DIV_BITS'((1 << (DIV_BITS - 1)) | ((1 << (DIV_BITS - 2)) - 1));
    // Last clk of SCLK low: sample MISO here, the rise follows.
    localparam logic [DIV_BITS-1:0] CntSmp  = DIV_BITS'((1 << (DIV_BITS - 1)) - 1);
    // Last clk of SCLK high: shift here, the fall follows.
    localparam logic [DIV_BITS-1:0] CntShf  = '1;
    localparam logic [GapW-1:0]     GapLast = GapW'(GAP_CLKS - 1);

    typedef enum logic [2:0] {StIdle, StFrm1, StGap, StFrm2, StDone} state_e;

    state_e              state_q, state_d;
    logic [15:0]         shift_q;
    logic [DIV_BITS-1:0] cnt_q;
    logic [4:0]          bit_cnt_q;
    logic                first_fall_q;
    logic                miso_smp_q;
    logic [GapW-1:0]     gap_cnt_q;
    logic [2:0]          chnnl_q;

    logic        in_frame;
    logic        frame_start;
    logic        accept;
    logic        smp_pt;
    logic        shf_pt;
    logic        bits_done;
    logic        frame_end;
    logic        gap_done;
    logic [15:0] cmd;

    assign smp_pt    = (cnt_q == CntSmp);
    assign shf_pt    = (cnt_q == CntShf);
    assign bits_done = (bit_cnt_q == 5'd16);
    assign frame_end = in_frame && smp_pt && bits_done;
    assign gap_done  = (state_q == StGap) && (gap_cnt_q == GapLast);
    assign accept    = (state_q == StIdle) && strt_cnv;
    // Frame 1 uses the live channel; frame 2 reuses the one captured at the start.
    assign cmd       = {2'b00, (state_q == StIdle) ? chnnl : chnnl_q, 11'h000};
    assign MOSI      = shift_q[15];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (strt_cnv)  state_d = StFrm1;
            StFrm1:  if (frame_end) state_d = StGap;
            StGap:   if (gap_done)  state_d = StFrm2;
            StFrm2:  if (frame_end) state_d = StDone;
            StDone:                 state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // FSM-decoded outputs: frame activity, frame launch and SCLK
    always_comb begin
        in_frame    = (state_q == StFrm1) || (state_q == StFrm2);
        frame_start = accept || gap_done;
        SCLK        = in_frame ? cnt_q[DIV_BITS-1] : 1'b1;
    end

    // SPI datapath: divider, sample/shift and slave select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            first_fall_q <= 1'b0;
            miso_smp_q   <= 1'b0;
            a2d_SS_n     <= 1'b1;
        end else if (frame_start) begin
            shift_q      <= cmd;
            cnt_q        <= CntLoad;
            bit_cnt_q    <= '0;
            first_fall_q <= 1'b1;
            a2d_SS_n     <= 1'b0;
        end else if (in_frame) begin
            cnt_q <= cnt_q + DIV_BITS'(1);
            if (frame_end) begin
                a2d_SS_n <= 1'b1;
            end else if (smp_pt) begin
                miso_smp_q <= MISO;
            end
            if (shf_pt) begin
                // The first fall only opens the frame; MOSI[15] is already out.
                if (first_fall_q) begin
                    first_fall_q <= 1'b0;
                end else if (!bits_done) begin
                    shift_q   <= {shift_q[14:0], miso_smp_q};
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
            end
        end
    end

    // Inter-frame gap timer, idle outside the gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else if (state_q != StGap) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
        end
    end

    // Channel capture, result register and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chnnl_q   <= '0;
            res       <= '0;
            cnv_cmplt <= 1'b0;
        end else if (accept) begin
            chnnl_q   <= chnnl;
            cnv_cmplt <= 1'b0;
        end else if (state_q == StDone) begin
            res       <= shift_q[11:0];
            cnv_cmplt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_a2d_spi_master.sv
// Self-checking bench for a2d_spi_master: SPI slave model, frame monitor,
// table of conversions with expectations from plain arithmetic, plus corner sequences.
module tb_a2d_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        miso = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        ss_n;
    logic        sclk;
    logic        mosi;

    int total = 0;
    int bad = 0;

    a2d_spi_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .MISO      (miso),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (ss_n),
        .SCLK      (sclk),
        .MOSI      (mosi)
    );

    always #5 clk = ~clk;

    // Per-frame records, appended when SS_n rises
    logic [15:0] frm_mosi[$];
    int          frm_len[$];
    int          frm_rises[$];
    int          gap_q[$];

    // Slave: word chosen by frame index inside the current conversion
    int          sl_k = 0;
    int          sl_base = 0;
    logic [15:0] sl_w1 = 16'h0;
    logic [15:0] sl_w2 = 16'h0;

    // Slave drives the next bit on every SCLK fall, MSB first
    always @(negedge sclk or posedge ss_n) begin
        if (ss_n) begin
            sl_k = 0;
        end else if (sl_k < 16) begin
            miso = (frm_mosi.size() == sl_base) ? sl_w1[15-sl_k] : sl_w2[15-sl_k];
            sl_k++;
        end
    end

    // Monitor: frame length, MOSI capture on SCLK rises, SCLK phase lengths, gaps
    logic        ss_p = 1'b1;
    logic        sclk_p = 1'b1;
    logic        mosi_p = 1'b0;
    int          low_len = 0;
    int          hi_len = 1000;
    int          run_len = 0;
    int          rises = 0;
    int          tim_err = 0;
    bit          first_hi = 1'b1;
    logic [15:0] mword = 16'h0;

    always @(negedge clk) begin
        if (!ss_n) begin
            if (ss_p) begin
                gap_q.push_back(hi_len);
                low_len  = 0;
                rises    = 0;
                mword    = 16'h0;
                run_len  = 0;
                first_hi = 1'b1;
            end
            low_len++;
            if (!ss_p && sclk != sclk_p) begin
                if (sclk) begin
                    if (run_len != 16) tim_err++;
                    if (mosi != mosi_p) tim_err++;
                    mword = {mword[14:0], mosi};
                    rises++;
                end else begin
                    if (!first_hi && run_len != 16) tim_err++;
                    first_hi = 1'b0;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
        end else begin
            if (!ss_p) begin
                frm_mosi.push_back(mword);
                frm_len.push_back(low_len);
                frm_rises.push_back(rises);
                hi_len = 1;
            end else begin
                hi_len++;
            end
        end
        ss_p   = ss_n;
        sclk_p = sclk;
        mosi_p = mosi;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One full conversion; optional strt_cnv re-pulse (chnnl=2) during frame 2
    task automatic run_conv(input logic [2:0] ch, input logic [15:0] w1, input logic [15:0] w2,
                            input bit repulse, input logic [11:0] exp_res,
                            input logic [15:0] exp_cmd);
        int nb;
        int gb;
        int te;
        int lat;
        bit pulsed;
        nb = frm_mosi.size();
        gb = gap_q.size();
        te = tim_err;
        sl_base = nb;
        sl_w1 = w1;
        sl_w2 = w2;
        chnnl = ch;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl = ~ch;
        chk("cmplt_cleared_on_start", cnv_cmplt, 1'b0);
        lat = 0;
        pulsed = 1'b0;
        while (!cnv_cmplt && lat < 3000) begin
            @(negedge clk);
            lat++;
            strt_cnv = 1'b0;
            if (repulse && !pulsed && frm_mosi.size() == nb + 1 && !ss_n) begin
                strt_cnv = 1'b1;
                chnnl = 3'd2;
                pulsed = 1'b1;
            end
        end
        strt_cnv = 1'b0;
        chk_rng("latency", lat, 1107, 1111);
        chk("res", res, exp_res);
        chk("led_res_hi", res[11:4], exp_res[11:4]);
        chk("frame_count", frm_mosi.size() - nb, 2);
        if (frm_mosi.size() >= nb + 2 && gap_q.size() >= gb + 2) begin
            chk("frm1_mosi", frm_mosi[nb], exp_cmd);
            chk("frm2_mosi", frm_mosi[nb+1], exp_cmd);
            chk("frm1_len", frm_len[nb], 537);
            chk("frm2_len", frm_len[nb+1], 537);
            chk("frm1_rises", frm_rises[nb], 16);
            chk("frm2_rises", frm_rises[nb+1], 16);
            chk_rng("gap_len", gap_q[gb+1], 32, 100000);
        end else begin
            chk("frame_records", frm_mosi.size() - nb, 2);
        end
        chk("sclk_timing_errs", tim_err - te, 0);
        repeat (40) @(negedge clk);
        chk("cmplt_held", cnv_cmplt, 1'b1);
        chk("res_held", res, exp_res);
        chk("no_extra_frame", frm_mosi.size() - nb, 2);
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] w1;
        logic [15:0] w2;
        bit          repulse;
        logic [11:0] exp_res;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t        v;
        int          nb;
        int          lat;
        logic [15:0] rw;

        // Table: expected result is the low 12 bits of the frame-2 slave word,
        // expected command is channel * 2048
        vecs.push_back('{3'd5, 16'hFFFF, 16'h0ABC, 1'b0, 12'hABC, 16'h2800});
        vecs.push_back('{3'd5, 16'h1234, 16'h0ABC, 1'b1, 12'hABC, 16'h2800});
        for (int c = 0; c < 8; c++) begin
            v.ch = 3'(c);
            v.w1 = 16'(c * 4099 + 77);
            v.w2 = 16'(c * 512);
            v.repulse = 1'b0;
            v.exp_res = 12'(c * 512);
            v.exp_cmd = 16'(c * 2048);
            vecs.push_back(v);
        end
        for (int r = 0; r < 4; r++) begin
            rw = 16'($urandom);
            v.ch = 3'($urandom_range(0, 7));
            v.w1 = 16'($urandom);
            v.w2 = rw;
            v.repulse = 1'($urandom_range(0, 1));
            v.exp_res = 12'(rw % 4096);
            v.exp_cmd = 16'(v.ch * 2048);
            vecs.push_back(v);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ss_n", ss_n, 1'b1);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_cmplt", cnv_cmplt, 1'b0);
        chk("rst_res", res, 12'h000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            run_conv(vecs[i].ch, vecs[i].w1, vecs[i].w2, vecs[i].repulse,
                     vecs[i].exp_res, vecs[i].exp_cmd);
        end

        // strt_cnv held across the DONE cycle: ignored there, accepted one clk later
        nb = frm_mosi.size();
        sl_base = nb;
        sl_w1 = 16'h5555;
        sl_w2 = 16'h0123;
        chnnl = 3'd1;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        lat = 0;
        while (lat < 1100) begin
            @(negedge clk);
            lat++;
        end
        strt_cnv = 1'b1;
        chnnl = 3'd4;
        lat = 0;
        while (!cnv_cmplt && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("done_cmplt_set", cnv_cmplt, 1'b1);
        chk("done_ss_high", ss_n, 1'b1);
        chk("done_res", res, 12'h123);
        nb = frm_mosi.size();
        sl_base = nb;
        sl_w2 = 16'h0FED;
        @(negedge clk);
        strt_cnv = 1'b0;
        chk("accept_after_done_clr", cnv_cmplt, 1'b0);
        chk("accept_after_done_ss", ss_n, 1'b0);
        lat = 0;
        while (!cnv_cmplt && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk_rng("latency_after_done", lat, 1107, 1111);
        chk("res_after_done", res, 12'hFED);
        if (frm_mosi.size() > nb) chk("cmd_after_done", frm_mosi[nb], 16'h2000);
        else chk("frame_after_done", frm_mosi.size() - nb, 1);

        // Asynchronous reset in the middle of frame 1
        chnnl = 3'd6;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_ss_low", ss_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", ss_n, 1'b1);
        chk("midrst_sclk", sclk, 1'b1);
        chk("midrst_cmplt", cnv_cmplt, 1'b0);
        chk("midrst_res", res, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nb = frm_mosi.size();
        repeat (100) @(negedge clk);
        chk("post_rst_idle_ss", ss_n, 1'b1);
        chk("post_rst_idle_sclk", sclk, 1'b1);
        chk("post_rst_no_frame", frm_mosi.size() - nb, 0);

        // Recovery after reset
        run_conv(3'd3, 16'hAAAA, 16'h0F0F, 1'b0, 12'hF0F, 16'h1800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
